// File: rtl/parity_frame_checker.sv
// Serial framed parity checker: DATA_W data bits LSB-first, then one parity bit, even or odd parity.
// Latency: DATA_W+1 valid bits after START; DONE rises the cycle after the parity bit is sampled.
// Backpressure: none; VALID low stalls the frame indefinitely, ABORT drops it without a DONE.
// Optional build macro PARITY_STICKY_EN adds err_clr / err_sticky (sticky error flag, counter clear).
module parity_frame_checker #(
    parameter int DATA_W     = 4,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              valid,
    input  logic              bit_in,
`ifdef PARITY_STICKY_EN
    input  logic              err_clr,
    output logic              err_sticky,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              pec,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;

    // Counter must hold 0..DATA_W (it reaches DATA_W while waiting for parity).
    localparam int             CW       = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_W - 1);
    localparam logic           ODD      = (ODD_PARITY != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              run_par;

    logic par_hit;
    logic pec_new;
    logic err_hit;

    // Parity bit accepted this cycle (abort takes priority) and its error verdict.
    assign par_hit = (state == S_PAR) && valid && !abort;
    assign pec_new = run_par ^ bit_in ^ ODD;
    assign err_hit = par_hit && pec_new;

    assign busy = (state != S_IDLE);

    // Frame sequencing: collect DATA_W bits, then the parity bit; abort returns to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            run_par <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        run_par <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (valid) begin
                        // Right shift: after DATA_W bits the first bit lands in bit 0.
                        shreg   <= {bit_in, shreg[DATA_W-1:1]};
                        run_par <= run_par ^ bit_in;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= S_PAR;
                        end
                    end
                end
                S_PAR: begin
                    if (valid) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Frame result: one-cycle done strobe, data and parity verdict held until the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            data_out <= '0;
            pec      <= 1'b0;
        end else begin
            done <= par_hit;
            if (par_hit) begin
                data_out <= shreg;
                pec      <= pec_new;
            end
        end
    end

`ifdef PARITY_STICKY_EN
    // Error counter and sticky flag; an error on the clear edge wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt    <= '0;
            err_sticky <= 1'b0;
        end else if (err_clr) begin
            err_cnt    <= err_hit ? CNT_W'(1) : '0;
            err_sticky <= err_hit;
        end else if (err_hit) begin
            err_sticky <= 1'b1;
            if (err_cnt != CNT_MAX) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
`else
    // Saturating count of frames that completed with a parity error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_hit && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
